// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch bus: level request with variable-latency one-cycle ack.
interface instruction_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time from imem and presents a
// registered {pc, instruction, valid} bundle to decode with stall/redirect/timeout handling.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter int unsigned MAX_WAIT  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    instruction_fetch_if.master imem,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [63:0]         i_redirect_pc,
    output logic                o_valid,
    output logic [63:0]         o_pc,
    output logic [31:0]         o_instruction,
    output logic                o_fetch_fault
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StReq, StKill, StHold, StFault} state_e;

    state_e            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       kill_pc_q, kill_pc_d;
    logic [63:0]       hold_pc_q, hold_pc_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [63:0]       out_pc_q, out_pc_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              fault_q, fault_d;

    logic              ack;
    logic              timeout;
    logic [63:0]       target;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_pc_d    = kill_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        wait_d       = wait_q;
        valid_d      = valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        fault_d      = fault_q;

        // An ack is only meaningful while our request is actually on the bus.
        ack     = imem.imem_ack && req_q;
        timeout = req_q && !ack && (wait_q == WaitLast);
        target  = {i_redirect_pc[63:2], 2'b00};

        if (!i_stall) begin
            valid_d     = 1'b0;
            out_instr_d = NOP_INSTR;
        end

        if (i_redirect) begin
            valid_d     = 1'b0;
            out_instr_d = NOP_INSTR;
            wait_d      = '0;
            // An unacked request must complete at its old address before the PC can move.
            if (req_q && !ack) begin
                state_d   = StKill;
                kill_pc_d = target;
            end else begin
                state_d = StReq;
                pc_d    = target;
                fault_d = 1'b0;
            end
        end else begin
            if (req_q) begin
                wait_d = ack ? '0 : wait_q + WaitW'(1);
            end
            unique case (state_q)
                StReq: begin
                    if (ack) begin
                        pc_d = pc_q + 64'd4;
                        if (i_stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem.imem_rdata;
                            state_d      = StHold;
                        end else begin
                            valid_d     = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = imem.imem_rdata;
                        end
                    end else if (timeout) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                        wait_d  = '0;
                    end
                end
                StKill: begin
                    if (ack) begin
                        pc_d    = kill_pc_q;
                        state_d = StReq;
                    end else if (timeout) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                        wait_d  = '0;
                    end
                end
                StHold: begin
                    if (!i_stall) begin
                        valid_d     = 1'b1;
                        out_pc_d    = hold_pc_q;
                        out_instr_d = hold_instr_q;
                        state_d     = StReq;
                    end
                end
                StFault: begin
                end
            endcase
        end

        req_d = (state_d == StReq) || (state_d == StKill);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            kill_pc_q    <= RESET_PC;
            hold_pc_q    <= 64'h0;
            hold_instr_q <= NOP_INSTR;
            wait_q       <= '0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            out_pc_q     <= 64'h0;
            out_instr_q  <= NOP_INSTR;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_pc_q    <= kill_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            wait_q       <= wait_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            fault_q      <= fault_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign o_valid        = valid_q;
    assign o_pc           = out_pc_q;
    assign o_instruction  = out_instr_q;
    assign o_fetch_fault  = fault_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front-end pipeline stage that sits directly upstream of instruction decode and supplies its i_pc / i_instruction inputs.
- Owns the 64-bit program counter.
- Issues word fetches to the instruction memory over a req/ack handshake that allows variable latency.
- Presents a registered {pc, instruction, valid} bundle to decode.
- Handles downstream stall, branch redirect/flush, and a memory-timeout fault.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset
MAX_WAIT, 16, cycles a request may stay unacknowledged before fault (>=1)
NOP_INSTR, 32'h0000_0013, instruction word driven while o_valid=0 (addi x0,x0,0)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
o_imem_req  output  1  fetch request, level; held until acknowledged
o_imem_addr  output  64  fetch address; equals pc, stable while o_imem_req=1
i_imem_ack  input  1  one-cycle pulse, i_imem_rdata valid this cycle
i_imem_rdata  input  32  fetched instruction word
i_stall  input  1  decode cannot accept; hold output register
i_redirect  input  1  branch taken / flush request
i_redirect_pc  input  64  redirect target
o_valid  output  1  output bundle holds a real instruction
o_pc  output  64  PC of o_instruction
o_instruction  output  32  instruction to decode (NOP_INSTR when o_valid=0)
o_fetch_fault  output  1  sticky: memory timed out

Behaviour:
Reset (async assert, sync-safe deassert):
- pc=RESET_PC, state=REQ, o_imem_req=0, o_valid=0, o_pc=0, o_instruction=NOP_INSTR, o_fetch_fault=0, wait counter=0, hold buffer empty.
- o_imem_req is registered and first rises on the first clock edge after deassertion.

States:
- REQ: request outstanding, o_imem_req=1, o_imem_addr=pc.
- KILL: request outstanding but already squashed by a redirect.
- HOLD: a fetched word is parked in the hold buffer because decode stalled; o_imem_req=0.
- FAULT: o_imem_req=0, o_fetch_fault=1.

REQ:
- Ack and !i_stall: output reg <= {1, pc, rdata}; pc <= pc+4; stay in REQ. This gives back-to-back fetch, 1 instruction/cycle with zero-wait memory.
- Ack and i_stall: {pc, rdata} -> hold buffer; pc <= pc+4; go to HOLD; o_imem_req drops the next cycle.
- No ack: wait counter increments. When the counter reaches MAX_WAIT: go to FAULT, o_imem_req=0.
- The wait counter clears on every ack and on every redirect.

HOLD:
- When i_stall is low: output reg <= hold buffer (o_valid=1); go to REQ.
- Fetch-to-decode latency is therefore 1 cycle after the ack, or 1 cycle after stall release.

KILL:
- o_imem_addr stays at the old pc; the memory protocol forbids changing the address before the ack.
- On ack: the data is discarded, pc <= the latched redirect target, go to REQ.
- The timeout counter also runs here.

Output register:
- When i_stall=1 and no redirect, all outputs hold their values.
- When i_stall=0 and no new word is captured, o_valid <= 0 and o_instruction <= NOP_INSTR (a bubble).

Redirect (highest priority, overrides stall):
- o_valid <= 0 next cycle; the hold buffer is cleared.
- Target is captured with bits [1:0] forced to 0.
- REQ with no ack this cycle: go to KILL with the target latched.
- REQ with ack this cycle, HOLD, or FAULT: pc <= target, go to REQ. Redirect clears o_fetch_fault.
- KILL: the latched target is overwritten; the newest redirect wins.

Other rules:
- pc+4 wraps modulo 2^64 with no flag.
- Only one request is ever outstanding.
- i_imem_ack while o_imem_req=0 is ignored.
- Asynchronous reset at any point, including in KILL or HOLD, returns to the reset state. An in-flight ack arriving after reset is ignored because o_imem_req=0.

Test Plan:
1. Reset release, memory acks every cycle with rdata=0x00A00093,0x00B00113,... -> o_imem_addr 0,4,8; o_valid rises 1 cycle after the first ack; o_pc 0,4,8 in consecutive cycles.
2. i_stall high for 3 cycles coinciding with the ack of pc=8 -> outputs frozen at pc=4; o_imem_req low during HOLD; pc=8 word is presented the cycle after stall falls; no instruction lost or duplicated.
3. Memory with 3-cycle ack latency, i_redirect_pc=0x100 pulsed 1 cycle after the req for pc=0x10 -> o_imem_addr stays 0x10 until ack; that word is never presented (o_valid=0); next req addr=0x100.
4. Redirect and i_stall high in the same cycle -> o_valid=0 next cycle despite the stall; next fetch at the target.
5. No ack for MAX_WAIT=16 cycles -> o_fetch_fault=1 and o_imem_req=0 after 16 cycles; redirect to 0x200 clears the fault and a req to 0x200 issues.
6. i_rst_n pulsed low mid-HOLD and mid-KILL -> all outputs at their reset values immediately (asynchronously); fetch restarts at RESET_PC; i_redirect_pc=0x103 yields fetch address 0x100.
